// File: rtl/seg_scan_display.sv
// Scans latched BCD digits onto a common-anode 7-segment display.
// SEG_LEADING_ZERO_BLANK_EN: blank leading zero digits.
module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [DW-1:0]                div_cnt;
    logic [IW-1:0]                digit_idx;
    logic [NUM_DIGITS-1:0][3:0]   shadow_bcd;
    logic [NUM_DIGITS-1:0]        shadow_dp;
    logic                         tick;
    logic [3:0]                   cur_bcd;
    logic                         cur_dp;
    logic                         blank;
    logic [6:0]                   seg_next;
    logic [NUM_DIGITS-1:0]        an_next;

    assign tick    = (div_cnt == DIV_LAST);
    assign cur_bcd = shadow_bcd[digit_idx];
    assign cur_dp  = shadow_dp[digit_idx];
    assign an_next = ~(NUM_DIGITS'(1) << digit_idx);

    always_comb begin
        case (cur_bcd)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h3F;
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  run;

    // A digit stays blank only while it and every digit above it are
    // zero with no decimal point lit; digit 0 always shows.
    always_comb begin
        lead_zero = '0;
        run       = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run          = run && (shadow_bcd[k] == 4'd0) && !shadow_dp[k];
            lead_zero[k] = run;
        end
    end

    assign blank = lead_zero[digit_idx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            an_o       <= '1;
            seg_o      <= 7'h7F;
            dp_o       <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end
            if (load_i) begin
                shadow_bcd <= bcd_i;
                shadow_dp  <= dp_i;
            end
            an_o  <= an_next;
            seg_o <= blank ? 7'h7F : seg_next;
            dp_o  <= blank | ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: vector table, directed corners, random vs model.
// Honours SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_display;

    localparam int N   = 4;
    localparam int DIV = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [15:0]  bcd_i = '0;
    logic [3:0]   dp_i = '0;
    logic         load_i = 1'b0;
    logic [6:0]   seg_o;
    logic         dp_o;
    logic [3:0]   an_o;

    seg_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(DIV)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bcd_i  (bcd_i),
        .dp_i   (dp_i),
        .load_i (load_i),
        .seg_o  (seg_o),
        .dp_o   (dp_o),
        .an_o   (an_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [6:0] dec_tab [16];

    // reference state: edges since reset and the latched values
    int          m_t   = 0;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_dp  = '0;

    task automatic cmp(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic [15:0] b,
                       input logic [3:0] d, input bit mchk);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int         k;
        rst_i  = r;
        load_i = l;
        bcd_i  = b;
        dp_i   = d;
        @(posedge clk_i);
        if (r) begin
            ea = 4'hF;
            es = 7'h7F;
            ed = 1'b1;
        end else begin
            k  = (m_t / DIV) % N;
            ea = ~(4'b0001 << k);
            es = dec_tab[(m_bcd >> (4 * k)) & 16'hF];
            ed = ~m_dp[k];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (k > 0 && (m_bcd >> (4 * k)) == 0 && (m_dp >> k) == 0) begin
                es = 7'h7F;
                ed = 1'b1;
            end
`endif
        end
        if (r) begin
            m_t   = 0;
            m_bcd = '0;
            m_dp  = '0;
        end else begin
            m_t++;
            if (l) begin
                m_bcd = b;
                m_dp  = d;
            end
        end
        #1;
        if (mchk) begin
            cmp("model_an", {4'h0, an_o}, {4'h0, ea});
            cmp("model_seg", {1'b0, seg_o}, {1'b0, es});
            cmp("model_dp", {7'h0, dp_o}, {7'h0, ed});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'b1);
        end
    endtask

    task automatic check_digit(input int k, input logic [6:0] es,
                               input logic ed);
        logic [3:0] tgt;
        bit         found;
        tgt   = ~(4'b0001 << k);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (an_o == tgt) found = 1'b1;
            else idle(1);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL digit%0d_wait got an %0h want %0h", k, an_o, tgt);
        end else begin
            cmp($sformatf("digit%0d_seg", k), {1'b0, seg_o}, {1'b0, es});
            cmp($sformatf("digit%0d_dp", k), {7'h0, dp_o}, {7'h0, ed});
        end
    endtask

    function automatic vec_t mk(logic r, logic l, logic [15:0] b,
                                logic [3:0] d, logic [3:0] a,
                                logic [6:0] s, logic o);
        vec_t v;
        v.rst = r; v.ld = l; v.bcd = b; v.dp = d;
        v.an = a; v.seg = s; v.dpo = o;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        bit found;
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

        tbl[0] = mk(1, 0, 16'hFFFF, 4'hF, 4'hF, 7'h7F, 1);
        for (int i = 1; i <= 4; i++)
            tbl[i] = mk(0, 0, 16'hFFFF, 4'hF, 4'hE, 7'h40, 1);
        tbl[5] = mk(0, 1, 16'h1234, 4'b0100, 4'hD, LZ, 1);
        for (int i = 6; i <= 8; i++)
            tbl[i] = mk(0, 0, 16'h5678, 4'hF, 4'hD, 7'h30, 1);
        for (int i = 9; i <= 12; i++)
            tbl[i] = mk(0, 0, 16'h5678, 4'hF, 4'hB, 7'h24, 0);
        for (int i = 13; i <= 16; i++)
            tbl[i] = mk(0, 0, 16'h5678, 4'hF, 4'h7, 7'h79, 1);
        tbl[17] = mk(0, 0, 16'h0000, 4'h0, 4'hE, 7'h19, 1);

        repeat (2) @(posedge clk_i);
        #1;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].rst, tbl[i].ld, tbl[i].bcd, tbl[i].dp, 1'b0);
            cmp($sformatf("tbl%0d_an", i), {4'h0, an_o}, {4'h0, tbl[i].an});
            cmp($sformatf("tbl%0d_seg", i), {1'b0, seg_o}, {1'b0, tbl[i].seg});
            cmp($sformatf("tbl%0d_dp", i), {7'h0, dp_o}, {7'h0, tbl[i].dpo});
        end

        // inputs wander without load: full scan unchanged
        idle(16);
        check_digit(3, 7'h79, 1'b1);
        check_digit(2, 7'h24, 1'b0);

        cyc(1'b0, 1'b1, 16'h9AF0, 4'h0, 1'b1);
        idle(1);
        check_digit(0, 7'h40, 1'b1);
        check_digit(1, 7'h3F, 1'b1);
        check_digit(2, 7'h3F, 1'b1);
        check_digit(3, 7'h10, 1'b1);

        // load coinciding with a tick
        while (m_t % DIV != DIV - 1) idle(1);
        cyc(1'b0, 1'b1, 16'h8765, 4'b1111, 1'b1);
        idle(1);
        cmp("tick_load_seg", {1'b0, seg_o},
            {1'b0, dec_tab[(16'h8765 >> (4 * ((m_t - 1) / DIV % N))) & 16'hF]});
        cmp("tick_load_dp", {7'h0, dp_o}, 8'h0);

        // reset while digit 2 active
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (an_o == 4'b1011) found = 1'b1;
            else idle(1);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL rst_wait got an %0h want b", an_o);
        end
        cyc(1'b1, 1'b1, 16'h9999, 4'hF, 1'b1);
        cmp("rst_an", {4'h0, an_o}, 8'h0F);
        cmp("rst_seg", {1'b0, seg_o}, 8'h7F);
        cyc(1'b0, 1'b0, 16'h9999, 4'hF, 1'b1);
        cmp("post_rst_an", {4'h0, an_o}, 8'h0E);
        cmp("post_rst_seg", {1'b0, seg_o}, 8'h40);

        cyc(1'b0, 1'b1, 16'h0042, 4'h0, 1'b1);
        idle(1);
        check_digit(3, LZ, 1'b1);
        check_digit(2, LZ, 1'b1);
        check_digit(1, 7'h19, 1'b1);
        check_digit(0, 7'h24, 1'b1);
        cyc(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
        idle(1);
        check_digit(0, 7'h40, 1'b1);
        check_digit(1, LZ, 1'b1);
        check_digit(3, LZ, 1'b1);
        cyc(1'b0, 1'b1, 16'h0030, 4'b0100, 1'b1);
        idle(1);
        check_digit(2, 7'h40, 1'b0);
        check_digit(3, LZ, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                16'($urandom), 4'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the lab decade counters' 4-bit BCD count outputs.
- Latches up to NUM_DIGITS BCD digits and time-multiplexes them onto a common-anode 7-segment display (shared active-low segment bus, active-low digit enables).
- Sits between the counter chain and the board display pins.
- All outputs are registered to avoid glitching on the pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- SCAN_DIV, 100000: clk_i cycles each digit stays enabled; minimum 2.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- bcd_i  input  4*NUM_DIGITS  BCD digits; digit k = bcd_i[4k+3:4k]; digit 0 is rightmost.
- dp_i  input  NUM_DIGITS  decimal point request per digit; 1 = lit.
- load_i  input  1  strobe that captures bcd_i/dp_i into the shadow register.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  output  1  decimal point, active-low.
- an_o  output  NUM_DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
- Reset: one clock with rst_i=1 gives:
  - div_cnt=0, digit_idx=0, shadow digits=0, shadow dp=0.
  - an_o=all 1s, seg_o=7'h7F, dp_o=1 (display dark for that cycle).
  - Reset has priority over load_i and tick.
- Shadow register: on any edge with load_i=1, shadow <= {bcd_i, dp_i}. Otherwise it holds. The display never samples bcd_i directly.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps to 0. tick=1 in the cycle where div_cnt==SCAN_DIV-1.
- Digit index: on tick, digit_idx increments; from NUM_DIGITS-1 it wraps to 0. Scan order is 0,1,...,NUM_DIGITS-1,0,...
- Output register, updated every non-reset cycle from the current digit_idx and shadow:
  - an_o = all 1s except bit digit_idx = 0.
  - seg_o = decode(shadow digit[digit_idx]).
  - dp_o = ~shadow dp[digit_idx].
- Latency:
  - Output pins lag digit_idx/shadow by one cycle.
  - load_i at edge n is visible on seg_o after edge n+1 if that digit is active.
  - Each digit is enabled for exactly SCAN_DIV consecutive cycles.
- Decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10..15 are invalid and show '-' = 3F (only g lit).
- Simultaneous load_i and tick: both take effect at the same edge. The next digit shows the new shadow value.
- Reset mid-scan: the display returns to digit 0 and shadow is cleared. The first visible digit after release is digit 0 with value 0 (seg_o=40), appearing one cycle after reset deasserts.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit k > 0 is blanked (seg_o=7F, dp_o=1) when its shadow value is 0 and every digit above it is also 0.
  - Digit 0 is never blanked. Example: shadow 0,0,4,2 shows "  42".
  - Blanking is computed from the shadow register with the same one-cycle latency. an_o still scans normally.
  - A lit decimal point on a zero digit disables blanking for that digit and all digits below it.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
- Reset then idle:
  - an_o=1111 during reset.
  - One cycle after release: an_o=1110, seg_o=40.
  - an_o changes every 4 cycles: 1110, 1101, 1011, 0111, then back to 1110.
- load_i=1 with bcd_i=16'h1234, dp_i=4'b0100:
  - Digit0 seg=19, digit1 seg=30, digit2 seg=24 with dp_o=0, digit3 seg=79.
  - All other digits have dp_o=1.
- bcd_i changes without load_i: seg_o is unchanged over a full scan. Then load_i with 16'h9AF0 gives digit0=40, digit1=3F, digit2=3F, digit3=10.
- load_i asserted in the same cycle as a tick: the next digit shows the new value with no stale cycle beyond the defined one-cycle latency.
- rst_i pulsed while digit 2 is active:
  - an_o=1111 and seg_o=7F for the reset cycle.
  - Scan restarts at digit 0 showing 40; shadow is cleared.
- With SEG_LEADING_ZERO_BLANK_EN and bcd_i=16'h0042 loaded:
  - Digits 3 and 2 show seg_o=7F; digit1=19, digit0=24.
  - bcd_i=16'h0000 gives digit 0 only showing 40.
